// File: rtl/ram_lsu_bridge.sv
// Byte-addressed load/store front end for a single-port 32-bit word RAM.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and sign/zero extended.
module ram_lsu_bridge #(
   parameter int WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [11:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic        ram_wen,
   input  logic [31:0] ram_rdata
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MERGE, RESP} state_t;

   localparam logic [31:0] WORDS_L = WORDS;

   state_t      state, next_state;
   logic        we_q, signed_q, err_q;
   logic [1:0]  size_q, lane_q;
   logic [15:0] wdata_q;
   logic [31:0] rdata_q;
   logic        accept, illegal, word_store_q;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_val, merged;

   // The response leaves RESP through a register, so the pulse lands in the
   // following IDLE cycle; the bridge stays busy until that pulse is gone.
   assign req_ready    = (state == IDLE) && !resp_valid;
   assign accept       = req_valid && req_ready;
   assign word_store_q = we_q && (size_q == 2'd2);

   always_comb begin
      illegal = 1'b0;
      if (req_size == 2'd3)
         illegal = 1'b1;
      if ((req_size == 2'd1) && req_addr[0])
         illegal = 1'b1;
      if ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
         illegal = 1'b1;
      if ({2'b00, req_addr[31:2]} >= WORDS_L)
         illegal = 1'b1;
   end

   always_comb begin
      byte_lane = ram_rdata[{lane_q, 3'b000} +: 8];
      half_lane = ram_rdata[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         2'd0:    load_val = {{24{signed_q & byte_lane[7]}}, byte_lane};
         2'd1:    load_val = {{16{signed_q & half_lane[15]}}, half_lane};
         default: load_val = ram_rdata;
      endcase
      merged = ram_rdata;
      if (size_q == 2'd0)
         merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = illegal ? RESP : ISSUE;
         ISSUE:   next_state = word_store_q ? RESP : WAIT;
         WAIT:    next_state = we_q ? MERGE : RESP;
         MERGE:   next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         signed_q   <= 1'b0;
         err_q      <= 1'b0;
         size_q     <= 2'd0;
         lane_q     <= 2'd0;
         wdata_q    <= 16'd0;
         rdata_q    <= 32'd0;
         ram_addr   <= 12'd0;
         ram_wdata  <= 32'd0;
         ram_wen    <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q     <= req_we;
                  signed_q <= req_signed;
                  size_q   <= req_size;
                  lane_q   <= req_addr[1:0];
                  wdata_q  <= req_wdata[15:0];
                  err_q    <= illegal;
                  rdata_q  <= 32'd0;
                  if (!illegal) begin
                     ram_addr <= req_addr[13:2];
                     ram_wen  <= req_we && (req_size == 2'd2);
                     if (req_we && (req_size == 2'd2))
                        ram_wdata <= req_wdata;
                  end
               end
            end
            ISSUE: ram_wen <= 1'b0;
            WAIT: begin
               if (we_q) begin
                  ram_wdata <= merged;
                  ram_wen   <= 1'b1;
               end else begin
                  rdata_q <= load_val;
               end
            end
            MERGE: ram_wen <= 1'b0;
            default: ;
         endcase
         resp_valid <= (state == RESP);
         resp_err   <= (state == RESP) ? err_q : 1'b0;
         resp_rdata <= (state == RESP) ? rdata_q : 32'd0;
      end
   end

endmodule

// File: tb/tb_ram_lsu_bridge.sv
// Scoreboard bench for ram_lsu_bridge with a behavioural 1-cycle-read word RAM.
module tb_ram_lsu_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_wen;
   logic [31:0] ram_rdata;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   string       tag_q[$];
   int          resp_cycs[$];
   logic [31:0] mem [0:4095];
   int          cyc = 0;
   int          wen_count = 0;
   int          resp_count = 0;
   logic [11:0] last_waddr = 12'd0;
   logic        prev_rv = 1'b0;
   int          last_acc = 0;
   int          checks = 0;
   int          passed = 0;

   ram_lsu_bridge #(.WORDS(1024)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_wen    (ram_wen),
      .ram_rdata  (ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_wen) begin
         mem[ram_addr] <= ram_wdata;
         wen_count     <= wen_count + 1;
         last_waddr    <= ram_addr;
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp)
         passed++;
      else
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   // Every response pulse is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         checkOutput("resp_pulse_width", {31'd0, prev_rv}, 32'd0);
         checkOutput("resp_expected", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            exp_t  e;
            string t;
            e = sb.pop_front();
            t = tag_q.pop_front();
            checkOutput({t, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
            checkOutput({t, "_rdata"}, resp_rdata, e.rdata);
            checkOutput({t, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
         end
         resp_count++;
         resp_cycs.push_back(cyc);
      end
      prev_rv = resp_valid;
   end

   task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic we,
                                input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                                input logic exp_err, input logic [31:0] exp_rdata, input int lat,
                                input bit push, input bit hold);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      #1;
      req_valid  = 1'b1;
      req_addr   = addr;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_wdata  = wdata;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) begin
         checkOutput({tag, "_accept_timeout"}, 32'(n), 32'd0);
         req_valid = 1'b0;
         return;
      end
      e.err   = exp_err;
      e.rdata = exp_rdata;
      e.lat   = lat;
      e.acc   = cyc + 1;
      last_acc = e.acc;
      if (push) begin
         sb.push_back(e);
         tag_q.push_back(tag);
      end
      @(posedge clk);
      #1;
      checkOutput({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
      if (!hold) begin
         req_valid  = 1'b0;
         req_addr   = $urandom;
         req_wdata  = $urandom;
         req_we     = 1'($urandom);
         req_size   = 2'($urandom);
         req_signed = 1'($urandom);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_pending", 32'(sb.size()), 32'd0);
      sb.delete();
      tag_q.delete();
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [31:0] expLoad(input logic [31:0] w, input int lane,
                                           input logic [1:0] size, input logic sgn);
      logic [31:0] s;
      s = w >> (8 * lane);
      if (size == 2'd0)
         return sgn ? {{24{s[7]}}, s[7:0]} : {24'd0, s[7:0]};
      return sgn ? {{16{s[15]}}, s[15:0]} : {16'd0, s[15:0]};
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          w0;
      int          r0;
      logic [31:0] pat;
      for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_we = 1'b0;
      req_size = 2'd0; req_signed = 1'b0; req_wdata = 32'd0;

      repeat (3) @(negedge clk);
      checkOutput("rst_ram_wen", {31'd0, ram_wen}, 32'd0);
      checkOutput("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
      checkOutput("rst_ram_wdata", ram_wdata, 32'd0);
      checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);

      $display("[TB] word store then load");
      w0 = wen_count;
      applyStimulus("st_word", 32'h10, 1, 2'd2, 0, 32'hDEADBEEF, 0, 32'd0, 2, 1, 0);
      drain();
      checkOutput("st_word_wen_count", 32'(wen_count - w0), 32'd1);
      checkOutput("st_word_waddr", {20'd0, last_waddr}, 32'd4);
      checkOutput("st_word_mem", mem[4], 32'hDEADBEEF);
      applyStimulus("ld_word", 32'h10, 0, 2'd2, 0, 32'd0, 0, 32'hDEADBEEF, 3, 1, 0);
      drain();

      $display("[TB] byte read-modify-write and extension");
      applyStimulus("st_w20", 32'h20, 1, 2'd2, 0, 32'h11223344, 0, 32'd0, 2, 1, 0);
      applyStimulus("st_b22", 32'h22, 1, 2'd0, 0, 32'hFFFFFFAA, 0, 32'd0, 4, 1, 0);
      drain();
      checkOutput("rmw_byte_mem", mem[8], 32'h11AA3344);
      applyStimulus("ld_b22_s", 32'h22, 0, 2'd0, 1, 32'd0, 0, 32'hFFFFFFAA, 3, 1, 0);
      applyStimulus("ld_b22_u", 32'h22, 0, 2'd0, 0, 32'd0, 0, 32'h000000AA, 3, 1, 0);
      drain();

      $display("[TB] halfword");
      applyStimulus("st_h26", 32'h26, 1, 2'd1, 0, 32'h12348001, 0, 32'd0, 4, 1, 0);
      drain();
      checkOutput("rmw_half_mem", mem[9], 32'h80010000);
      applyStimulus("ld_h26_s", 32'h26, 0, 2'd1, 1, 32'd0, 0, 32'hFFFF8001, 3, 1, 0);
      applyStimulus("ld_h24_u", 32'h24, 0, 2'd1, 0, 32'd0, 0, 32'h00000000, 3, 1, 0);
      drain();

      $display("[TB] error responses");
      w0 = wen_count;
      applyStimulus("err_word_misal", 32'h02, 0, 2'd2, 0, 32'd0, 1, 32'd0, 1, 1, 0);
      applyStimulus("err_half_misal", 32'h01, 1, 2'd1, 0, 32'h1234, 1, 32'd0, 1, 1, 0);
      applyStimulus("err_size3", 32'h00, 0, 2'd3, 0, 32'd0, 1, 32'd0, 1, 1, 0);
      applyStimulus("err_range", 32'h1000, 0, 2'd2, 0, 32'd0, 1, 32'd0, 1, 1, 0);
      applyStimulus("err_hibits", 32'h80000010, 1, 2'd2, 0, 32'h1, 1, 32'd0, 1, 1, 0);
      drain();
      checkOutput("err_no_wen", 32'(wen_count - w0), 32'd0);
      checkOutput("err_mem_intact", mem[4], 32'hDEADBEEF);
      applyStimulus("st_top", 32'hFFC, 1, 2'd2, 0, 32'hCAFEF00D, 0, 32'd0, 2, 1, 0);
      applyStimulus("ld_top", 32'hFFC, 0, 2'd2, 0, 32'd0, 0, 32'hCAFEF00D, 3, 1, 0);
      drain();

      $display("[TB] lane sweep");
      pat = 32'h8C7F0A91;
      applyStimulus("st_w40", 32'h40, 1, 2'd2, 0, pat, 0, 32'd0, 2, 1, 0);
      for (int ln = 0; ln < 4; ln++)
         for (int sg = 0; sg < 2; sg++)
            applyStimulus($sformatf("ld_b%0d_s%0d", ln, sg), 32'h40 + 32'(ln), 0, 2'd0, sg[0],
                          32'd0, 0, expLoad(pat, ln, 2'd0, sg[0]), 3, 1, 0);
      for (int ln = 0; ln < 4; ln += 2)
         for (int sg = 0; sg < 2; sg++)
            applyStimulus($sformatf("ld_h%0d_s%0d", ln, sg), 32'h40 + 32'(ln), 0, 2'd1, sg[0],
                          32'd0, 0, expLoad(pat, ln, 2'd1, sg[0]), 3, 1, 0);
      applyStimulus("st_b43", 32'h43, 1, 2'd0, 0, 32'h0000005A, 0, 32'd0, 4, 1, 0);
      applyStimulus("st_h40", 32'h40, 1, 2'd1, 0, 32'h0000BEEF, 0, 32'd0, 4, 1, 0);
      drain();
      checkOutput("lane_rmw_mem", mem[16], 32'h5A7FBEEF);

      $display("[TB] reset during read-modify-write");
      mem[12] = 32'h55555555;
      w0 = wen_count;
      r0 = resp_count;
      applyStimulus("rst_rmw", 32'h30, 1, 2'd0, 0, 32'h000000AA, 0, 32'd0, 4, 0, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_wen", {31'd0, ram_wen}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("abort_no_write", 32'(wen_count - w0), 32'd0);
      checkOutput("abort_no_resp", 32'(resp_count - r0), 32'd0);
      checkOutput("abort_mem", mem[12], 32'h55555555);
      checkOutput("abort_ready", {31'd0, req_ready}, 32'd1);
      applyStimulus("ld_w30", 32'h30, 0, 2'd2, 0, 32'd0, 0, 32'h55555555, 3, 1, 0);
      drain();

      $display("[TB] back-to-back loads");
      resp_cycs.delete();
      begin
         int a1, a2, a3;
         applyStimulus("b2b_1", 32'h10, 0, 2'd2, 0, 32'd0, 0, 32'hDEADBEEF, 3, 1, 1);
         a1 = last_acc;
         applyStimulus("b2b_2", 32'h20, 0, 2'd2, 0, 32'd0, 0, 32'h11AA3344, 3, 1, 1);
         a2 = last_acc;
         applyStimulus("b2b_3", 32'h24, 0, 2'd2, 0, 32'd0, 0, 32'h80010000, 3, 1, 0);
         a3 = last_acc;
         checkOutput("b2b_acc_gap1", 32'(a2 - a1), 32'd5);
         checkOutput("b2b_acc_gap2", 32'(a3 - a2), 32'd5);
      end
      drain();
      checkOutput("b2b_resp_count", 32'(resp_cycs.size()), 32'd3);
      if (resp_cycs.size() == 3) begin
         checkOutput("b2b_resp_gap1", 32'(resp_cycs[1] - resp_cycs[0]), 32'd5);
         checkOutput("b2b_resp_gap2", 32'(resp_cycs[2] - resp_cycs[1]), 32'd5);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
